data_cache_ctrl: RTL
====================

DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, number of direct-mapped lines (power of two, 2..64).
REQ-002 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 cpu_rd  in  1  load request, held until stall=0.
REQ-007 cpu_wr  in  1  store request, held until stall=0.
REQ-008 cpu_addr  in  10  word address.
REQ-009 cpu_wdata  in  32  store data.
REQ-010 cpu_rdata  out  32  load data, valid when cpu_rd=1 and stall=0.
REQ-011 stall  out  1  request not completing this cycle.
REQ-012 mem_rd_en, mem_miss, mem_wr_en  out  1 each  memory controls.
REQ-013 mem_addr  out  10  memory word address.
REQ-014 mem_wdata  out  32  memory write data.
REQ-015 mem_rdata  in  128  line data, word k at bits [32k+31:32k].
REQ-016 mem_ready  in  1  one-cycle completion pulse from memory.
REQ-017 hit_cnt, miss_cnt  out  CNT_W each  statistics.

Function
REQ-018 Address split: offset=addr[1:0], index=addr[2+IW-1:2] where IW=log2(NUM_LINES), tag=remaining upper bits.
REQ-019 Write-through, no-write-allocate; per line one valid bit, tag and 128-bit data.
REQ-020 FSM states IDLE, FILL, WR_THRU; reset state IDLE.
REQ-021 IDLE, cpu_wr=1: latch addr/wdata, go WR_THRU, stall=1; cpu_wr has priority over simultaneous cpu_rd.
REQ-022 IDLE, cpu_rd=1, hit: cpu_rdata=array word combinationally, stall=0, stay IDLE.
REQ-023 IDLE, cpu_rd=1, miss: latch addr, go FILL, stall=1.
REQ-024 FILL: mem_rd_en=1, mem_miss=1, mem_addr={latched[9:2],2'b00}; on mem_ready write mem_rdata into line, set tag and valid, go IDLE; stall stays 1 through the ready cycle; the re-presented load hits next cycle.
REQ-025 WR_THRU: mem_wr_en=1, mem_addr/mem_wdata=latched values, held constant until mem_ready; on mem_ready update the cached word if the line is valid with matching tag, stall=0 that cycle, go IDLE.
REQ-026 mem_rd_en and mem_wr_en never both 1; both 0 in IDLE, so consecutive stores see a one-cycle deassertion gap.
REQ-027 mem_ready in IDLE is ignored.
REQ-028 Memory controls are decoded from state only (Moore); the only combinational CPU-to-output paths are cpu_rdata and stall.
REQ-029 cpu_rdata=0 when not (cpu_rd & hit & IDLE).

Reset
REQ-030 RST=1 at a clock edge: state=IDLE, all valid bits=0, latched addr/wdata=0, hit_cnt=miss_cnt=0; tag/data contents need not be reset.
REQ-031 Reset during FILL or WR_THRU abandons the transaction; memory controls are 0 from the next cycle and the line is not written.

Configuration
REQ-032 Macro CACHE_STATS_EN: when defined, hit_cnt increments on each IDLE read hit and miss_cnt on each IDLE read miss entry, both saturating at all-ones; stores are not counted.
REQ-033 Without CACHE_STATS_EN, hit_cnt and miss_cnt are tied to 0 and no counter flops exist; ports remain.

Structure
REQ-034 Shared package cache_pkg holds ADDR_W=10, WORD_W=32, LINE_W=128, WORDS_PER_LINE=4 and the FSM state encoding.
REQ-035 Sub-module cache_line_array holds valid/tag/data storage: one read port, line-fill write port, word write port, synchronous valid clear on RST.

Verification
REQ-036 Reset, then load 0x010 -> stall=1, mem_rd_en=mem_miss=1, mem_addr=0x010 until mem_ready; next cycle stall=0, cpu_rdata=mem_rdata[31:0]; miss_cnt=1.
REQ-037 Load 0x013 after 036 -> hit, stall=0 same cycle, cpu_rdata=word 3 of filled line, hit_cnt=1.
REQ-038 Store 0x011 data 0xDEADBEEF on cached line -> mem_wr_en held with mem_addr=0x011 until mem_ready; then load 0x011 hits returning 0xDEADBEEF.
REQ-039 Store to uncached 0x200 -> memory written, valid of index 0 unchanged; load 0x200 then misses.
REQ-040 Simultaneous cpu_rd=cpu_wr=1 -> WR_THRU entered, mem_rd_en stays 0.
REQ-041 Assert RST during FILL -> next cycle mem_rd_en=0, state IDLE, reload of same address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared widths and FSM state encoding for data_cache_ctrl
package cache_pkg;
   localparam int ADDR_W = 10;
   localparam int WORD_W = 32;
   localparam int LINE_W = 128;
   localparam int WORDS_PER_LINE = 4;
   typedef enum logic [1:0] {IDLE, FILL, WR_THRU} state_t;
endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: direct-mapped valid/tag/data storage
//   clk, RST               clock, sync active-high reset (clears valid bits only)
//   rd_idx -> rd_valid/rd_tag/rd_line   combinational read port
//   fill_en/fill_idx/fill_tag/fill_data whole-line fill, sets valid
//   wr_en/wr_idx/wr_off/wr_data         single-word update
module cache_line_array import cache_pkg::*; #(
   parameter int NUM_LINES = 8,
   parameter int IW = $clog2(NUM_LINES),
   parameter int TAG_W = ADDR_W - 2 - IW
) (
   input  logic              clk,
   input  logic              RST,
   input  logic [IW-1:0]     rd_idx,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_line,
   input  logic              fill_en,
   input  logic [IW-1:0]     fill_idx,
   input  logic [TAG_W-1:0]  fill_tag,
   input  logic [LINE_W-1:0] fill_data,
   input  logic              wr_en,
   input  logic [IW-1:0]     wr_idx,
   input  logic [1:0]        wr_off,
   input  logic [WORD_W-1:0] wr_data
);
   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]     tags [NUM_LINES];
   logic [LINE_W-1:0]    data [NUM_LINES];
   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_line  = data[rd_idx];
   always_ff @(posedge clk) begin
      if (RST) valid <= '0;
      else if (fill_en) valid[fill_idx] <= 1'b1;
   end
   // tag/data carry no reset; an invalid line is never read as a hit
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tags[fill_idx] <= fill_tag;
         data[fill_idx] <= fill_data;
      end else if (wr_en) data[wr_idx][{wr_off, 5'd0} +: WORD_W] <= wr_data;
   end
endmodule

// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped write-through, no-write-allocate data cache controller
//   clk, RST                      clock, sync active-high reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata -> cpu_rdata, stall   CPU side
//   mem_rd_en/mem_miss/mem_wr_en/mem_addr/mem_wdata, mem_rdata/mem_ready   memory side
//   hit_cnt/miss_cnt              statistics, live only when CACHE_STATS_EN is defined
module data_cache_ctrl import cache_pkg::*; #(
   parameter int NUM_LINES = 8,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [WORD_W-1:0] cpu_wdata,
   output logic [WORD_W-1:0] cpu_rdata,
   output logic              stall,
   output logic              mem_rd_en,
   output logic              mem_miss,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);
   localparam int IW = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - 2 - IW;
   state_t state;
   logic [ADDR_W-1:0] lat_addr, look_addr;
   logic [WORD_W-1:0] lat_wdata;
   logic              rd_valid, tag_match, hit, rd_hit, rd_miss;
   logic [TAG_W-1:0]  rd_tag;
   logic [LINE_W-1:0] rd_line;
   // one read port: CPU address while idle, latched store address during write-through
   assign look_addr = state == IDLE ? cpu_addr : lat_addr;
   assign tag_match = rd_valid && rd_tag == look_addr[ADDR_W-1:2+IW];
   assign hit       = state == IDLE && tag_match;
   assign rd_hit    = hit && cpu_rd && !cpu_wr;
   assign rd_miss   = state == IDLE && cpu_rd && !cpu_wr && !tag_match;
   assign cpu_rdata = hit && cpu_rd ? rd_line[{cpu_addr[1:0], 5'd0} +: WORD_W] : '0;
   assign stall     = state == FILL ? 1'b1 : state == WR_THRU ? !mem_ready : cpu_wr || (cpu_rd && !tag_match);
   assign mem_rd_en = state == FILL;
   assign mem_miss  = state == FILL;
   assign mem_wr_en = state == WR_THRU;
   assign mem_addr  = state == FILL ? {lat_addr[ADDR_W-1:2], 2'b00} : lat_addr;
   assign mem_wdata = lat_wdata;
   cache_line_array #(.NUM_LINES(NUM_LINES)) u_array (
      .clk(clk), .RST(RST),
      .rd_idx(look_addr[2+IW-1:2]), .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_line(rd_line),
      .fill_en(state == FILL && mem_ready && !RST), .fill_idx(lat_addr[2+IW-1:2]),
      .fill_tag(lat_addr[ADDR_W-1:2+IW]), .fill_data(mem_rdata),
      .wr_en(state == WR_THRU && mem_ready && tag_match && !RST), .wr_idx(lat_addr[2+IW-1:2]),
      .wr_off(lat_addr[1:0]), .wr_data(lat_wdata)
   );
   always_ff @(posedge clk) begin
      if (RST) begin
         state     <= IDLE;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         case (state)
            IDLE:
               if (cpu_wr) begin
                  lat_addr  <= cpu_addr;
                  lat_wdata <= cpu_wdata;
                  state     <= WR_THRU;
               end else if (rd_miss) begin
                  lat_addr <= cpu_addr;
                  state    <= FILL;
               end
            FILL:    if (mem_ready) state <= IDLE;
            WR_THRU: if (mem_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
`ifdef CACHE_STATS_EN
   // the re-presented load right after a fill belongs to the counted miss, not a new hit
   logic refill;
   always_ff @(posedge clk) begin
      if (RST) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         refill   <= 1'b0;
      end else begin
         refill <= state == FILL && mem_ready;
         if (rd_hit && !refill && ~&hit_cnt) hit_cnt <= hit_cnt + 1'b1;
         if (rd_miss && ~&miss_cnt) miss_cnt <= miss_cnt + 1'b1;
      end
   end
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif
endmodule
